// File: rtl/salamander_video_pkg.sv
// Shared video timing constants and the counter type used by the timing generator.
package salamander_video_pkg;

  localparam int CNT_W = 9;

  typedef logic [CNT_W-1:0] vcnt_t;

  // Default raster: 384 x 264 total, 256 x 224 visible
  localparam int H_TOTAL_DEF      = 384;
  localparam int H_ACTIVE_DEF     = 256;
  localparam int H_SYNC_START_DEF = 296;
  localparam int H_SYNC_WIDTH_DEF = 32;
  localparam int V_TOTAL_DEF      = 264;
  localparam int V_ACTIVE_DEF     = 224;
  localparam int V_SYNC_START_DEF = 236;
  localparam int V_SYNC_WIDTH_DEF = 8;
  localparam int BLK_DLY_DEF      = 2;

  // Registered timing flags, all active low
  typedef struct packed {
    logic hblank_n;
    logic vblank_n;
    logic hsync_n;
    logic vsync_n;
  } flags_t;

  // True when pos lies in [start, start+width); the sum is widened so it cannot wrap
  function automatic logic in_window(vcnt_t pos, vcnt_t start, vcnt_t width);
    return ({1'b0, pos} >= {1'b0, start}) &&
           ({1'b0, pos} <  ({1'b0, start} + {1'b0, width}));
  endfunction

endpackage

// File: rtl/video_tick_delay.sv
// Tick-enabled delay line; DEPTH stages, each advancing only on a pixel tick.
module video_tick_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    // No delay requested: pass straight through, clock/reset/tick are not needed
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, tick_i};
    assign q_o = d_i;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] sr_q;

    // Shift one stage per tick, clear asynchronously on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sr_q <= '0;
      end else if (tick_i) begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, blank/sync flags, delayed display enable, vblank IRQ.
module video_timing_gen
  import salamander_video_pkg::*;
#(
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_ACTIVE     = H_ACTIVE_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_WIDTH = H_SYNC_WIDTH_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_ACTIVE     = V_ACTIVE_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_WIDTH = V_SYNC_WIDTH_DEF,
  parameter int BLK_DLY      = BLK_DLY_DEF
) (
  input  logic       i_EMU_MCLK,
  input  logic       i_MRST_n,
  input  logic       i_EMU_CLK6MPCEN_n,
  input  logic       i_FLIP,
  output logic [8:0] o_HCOUNTER,
  output logic [8:0] o_VCOUNTER,
  output logic [7:0] o_FLIPH,
  output logic [7:0] o_FLIPV,
  output logic       o_HBLANK_n,
  output logic       o_VBLANK_n,
  output logic       o_HSYNC_n,
  output logic       o_VSYNC_n,
  output logic       o_SYNC_n,
  output logic       o_BLK,
  output logic       o_VBLANK_IRQ
);

  localparam vcnt_t H_LAST   = vcnt_t'(H_TOTAL - 1);
  localparam vcnt_t V_LAST   = vcnt_t'(V_TOTAL - 1);
  localparam vcnt_t H_ACT    = vcnt_t'(H_ACTIVE);
  localparam vcnt_t V_ACT    = vcnt_t'(V_ACTIVE);
  localparam vcnt_t V_ACT_LM = vcnt_t'(V_ACTIVE - 1);
  localparam vcnt_t H_SS     = vcnt_t'(H_SYNC_START);
  localparam vcnt_t H_SW     = vcnt_t'(H_SYNC_WIDTH);
  localparam vcnt_t V_SS     = vcnt_t'(V_SYNC_START);
  localparam vcnt_t V_SW     = vcnt_t'(V_SYNC_WIDTH);

  logic   tick;
  vcnt_t  h_q, h_d;
  vcnt_t  v_q, v_d;
  flags_t flags_q, flags_d;
  logic   irq_q, irq_d;
  logic   disp;
  logic   blk;

  assign tick = ~i_EMU_CLK6MPCEN_n;

  // Next raster position; flags are derived from it so they land on the same edge as the counters
  always_comb begin
    h_d   = h_q + vcnt_t'(1);
    v_d   = v_q;
    irq_d = 1'b0;
    if (h_q == H_LAST) begin
      h_d   = '0;
      v_d   = (v_q == V_LAST) ? '0 : v_q + vcnt_t'(1);
      irq_d = tick && (v_q == V_ACT_LM);
    end
    flags_d.hblank_n = (h_d < H_ACT);
    flags_d.vblank_n = (v_d < V_ACT);
    flags_d.hsync_n  = ~in_window(h_d, H_SS, H_SW);
    flags_d.vsync_n  = ~in_window(v_d, V_SS, V_SW);
  end

  // Counters and flags advance only on pixel ticks; reset values describe position 0,0
  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      h_q     <= '0;
      v_q     <= '0;
      flags_q <= '1;
    end else if (tick) begin
      h_q     <= h_d;
      v_q     <= v_d;
      flags_q <= flags_d;
    end
  end

  // IRQ is sampled every MCLK so it lasts exactly one cycle after the vblank-entry tick
  always_ff @(posedge i_EMU_MCLK or negedge i_MRST_n) begin
    if (!i_MRST_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign disp = flags_q.hblank_n & flags_q.vblank_n;

  video_tick_delay #(
    .WIDTH (1),
    .DEPTH (BLK_DLY)
  ) u_blk_dly (
    .clk_i  (i_EMU_MCLK),
    .rst_ni (i_MRST_n),
    .tick_i (tick),
    .d_i    (disp),
    .q_o    (blk)
  );

  assign o_HCOUNTER   = h_q;
  assign o_VCOUNTER   = v_q;
  assign o_FLIPH      = i_FLIP ? ~h_q[7:0] : h_q[7:0];
  assign o_FLIPV      = i_FLIP ? ~v_q[7:0] : v_q[7:0];
  assign o_HBLANK_n   = flags_q.hblank_n;
  assign o_VBLANK_n   = flags_q.vblank_n;
  assign o_HSYNC_n    = flags_q.hsync_n;
  assign o_VSYNC_n    = flags_q.vsync_n;
  assign o_SYNC_n     = flags_q.hsync_n & flags_q.vsync_n;
  assign o_BLK        = blk;
  assign o_VBLANK_IRQ = irq_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default raster plus a shrunken raster (BLK_DLY 2 and 0) so whole frames fit.
module tb_video_timing_gen;

  typedef struct packed {
    int ht; int ha; int hss; int hsw;
    int vt; int va; int vss; int vsw;
    int dly;
  } tp_t;

  localparam int  NI   = 3;
  localparam tp_t TP_D = '{ht:384, ha:256, hss:296, hsw:32, vt:264, va:224, vss:236, vsw:8, dly:2};
  localparam tp_t TP_S = '{ht:48,  ha:32,  hss:37,  hsw:4,  vt:20,  va:14,  vss:16,  vsw:2, dly:2};
  localparam tp_t TP_Z = '{ht:48,  ha:32,  hss:37,  hsw:4,  vt:20,  va:14,  vss:16,  vsw:2, dly:0};
  localparam tp_t [NI-1:0] TPS = {TP_Z, TP_S, TP_D};

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] v;
    logic [7:0] fh;
    logic [7:0] fv;
    logic hb, vb, hs, vs, s, blk, irq;
  } obs_t;

  typedef struct {
    int h; int v;
    bit hb; bit vb; bit hs; bit vs; bit s; bit blk;
  } vec_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic tick_n = 1'b1;
  logic flip   = 1'b0;

  logic [8:0] hc [NI];
  logic [8:0] vc [NI];
  logic [7:0] fh [NI];
  logic [7:0] fv [NI];
  logic hb [NI], vb [NI], hs [NI], vs [NI], sy [NI], blk [NI], irq [NI];

  int n_pass  = 0;
  int n_total = 0;
  int irq_cnt = 0;

  int m_h [NI];
  int m_v [NI];
  int m_ticks [NI];
  bit m_irq [NI];
  obs_t [NI-1:0] sbq [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    video_timing_gen #(
      .H_TOTAL      (TPS[g].ht),
      .H_ACTIVE     (TPS[g].ha),
      .H_SYNC_START (TPS[g].hss),
      .H_SYNC_WIDTH (TPS[g].hsw),
      .V_TOTAL      (TPS[g].vt),
      .V_ACTIVE     (TPS[g].va),
      .V_SYNC_START (TPS[g].vss),
      .V_SYNC_WIDTH (TPS[g].vsw),
      .BLK_DLY      (TPS[g].dly)
    ) u_dut (
      .i_EMU_MCLK        (clk),
      .i_MRST_n          (rst_n),
      .i_EMU_CLK6MPCEN_n (tick_n),
      .i_FLIP            (flip),
      .o_HCOUNTER        (hc[g]),
      .o_VCOUNTER        (vc[g]),
      .o_FLIPH           (fh[g]),
      .o_FLIPV           (fv[g]),
      .o_HBLANK_n        (hb[g]),
      .o_VBLANK_n        (vb[g]),
      .o_HSYNC_n         (hs[g]),
      .o_VSYNC_n         (vs[g]),
      .o_SYNC_n          (sy[g]),
      .o_BLK             (blk[g]),
      .o_VBLANK_IRQ      (irq[g])
    );
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, a, e);
  endtask

  function automatic obs_t get_act(input int i);
    obs_t a;
    a.h = hc[i];  a.v = vc[i];  a.fh = fh[i]; a.fv = fv[i];
    a.hb = hb[i]; a.vb = vb[i]; a.hs = hs[i]; a.vs = vs[i];
    a.s = sy[i];  a.blk = blk[i]; a.irq = irq[i];
    return a;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_h[i] = 0; m_v[i] = 0; m_ticks[i] = 0; m_irq[i] = 1'b0;
    end
    sbq.delete();
  endtask

  task automatic model_step(input int i, input bit tk);
    tp_t p;
    p = TPS[i];
    if (tk) begin
      m_irq[i] = (m_h[i] == p.ht - 1) && (m_v[i] == p.va - 1);
      m_ticks[i]++;
      m_h[i]++;
      if (m_h[i] == p.ht) begin
        m_h[i] = 0;
        m_v[i]++;
        if (m_v[i] == p.vt) m_v[i] = 0;
      end
    end else begin
      m_irq[i] = 1'b0;
    end
  endtask

  // Expected outputs from the raster position; o_BLK looks back dly ticks along the raster
  function automatic obs_t model_exp(input int i);
    tp_t p;
    obs_t e;
    int pos, ph, pv;
    logic [8:0] h9, v9;
    p  = TPS[i];
    h9 = 9'(m_h[i]);
    v9 = 9'(m_v[i]);
    e.h  = h9;
    e.v  = v9;
    e.hb = (m_h[i] < p.ha);
    e.vb = (m_v[i] < p.va);
    e.hs = !((m_h[i] >= p.hss) && (m_h[i] < p.hss + p.hsw));
    e.vs = !((m_v[i] >= p.vss) && (m_v[i] < p.vss + p.vsw));
    e.s  = e.hs & e.vs;
    if (p.dly == 0) begin
      e.blk = e.hb & e.vb;
    end else if (m_ticks[i] < p.dly) begin
      e.blk = 1'b0;
    end else begin
      pos = m_v[i] * p.ht + m_h[i] - p.dly;
      if (pos < 0) pos += p.ht * p.vt;
      ph = pos % p.ht;
      pv = pos / p.ht;
      e.blk = (ph < p.ha) && (pv < p.va);
    end
    e.irq = m_irq[i];
    e.fh  = flip ? ~h9[7:0] : h9[7:0];
    e.fv  = flip ? ~v9[7:0] : v9[7:0];
    return e;
  endfunction

  // One MCLK: drive tick at negedge, queue expectations, compare #1 after the rising edge
  task automatic cycle(input bit tk);
    obs_t [NI-1:0] e;
    obs_t a;
    @(negedge clk);
    tick_n = !tk;
    for (int i = 0; i < NI; i++) begin
      model_step(i, tk);
      e[i] = model_exp(i);
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    for (int i = 0; i < NI; i++) begin
      a = get_act(i);
      chk($sformatf("sb_dut%0d h=%0d v=%0d", i, m_h[i], m_v[i]), 64'(a), 64'(e[i]));
    end
  endtask

  task automatic cyc_cnt(input bit tk);
    cycle(tk);
    if (irq[1]) irq_cnt++;
  endtask

  task automatic run_to(input int i, input int h, input int v, input int budget);
    int n;
    n = 0;
    while (!(m_h[i] == h && m_v[i] == v) && n < budget) begin
      cycle(1'b1);
      n++;
    end
    if (!(m_h[i] == h && m_v[i] == v)) begin
      n_total++;
      $display("FAIL run_to dut%0d: budget %0d expired, at h=%0d v=%0d required h=%0d v=%0d",
               i, budget, m_h[i], m_v[i], h, v);
    end
  endtask

  task automatic check_reset(input string tag);
    obs_t e;
    for (int i = 0; i < NI; i++) begin
      e.h = 9'd0; e.v = 9'd0;
      e.fh = flip ? 8'hff : 8'h00;
      e.fv = flip ? 8'hff : 8'h00;
      e.hb = 1'b1; e.vb = 1'b1; e.hs = 1'b1; e.vs = 1'b1; e.s = 1'b1;
      e.blk = (TPS[i].dly == 0);
      e.irq = 1'b0;
      chk($sformatf("%s_dut%0d", tag, i), 64'(get_act(i)), 64'(e));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt [15];
    int n, ih, iv;

    // h, v, hblank_n, vblank_n, hsync_n, vsync_n, sync_n, blk  (default raster)
    vt[0]  = '{1,   0,  1, 1, 1, 1, 1, 0};
    vt[1]  = '{2,   0,  1, 1, 1, 1, 1, 1};
    vt[2]  = '{255, 0,  1, 1, 1, 1, 1, 1};
    vt[3]  = '{256, 0,  0, 1, 1, 1, 1, 1};
    vt[4]  = '{257, 0,  0, 1, 1, 1, 1, 1};
    vt[5]  = '{258, 0,  0, 1, 1, 1, 1, 0};
    vt[6]  = '{295, 0,  0, 1, 1, 1, 1, 0};
    vt[7]  = '{296, 0,  0, 1, 0, 1, 0, 0};
    vt[8]  = '{327, 0,  0, 1, 0, 1, 0, 0};
    vt[9]  = '{328, 0,  0, 1, 1, 1, 1, 0};
    vt[10] = '{383, 0,  0, 1, 1, 1, 1, 0};
    vt[11] = '{0,   1,  1, 1, 1, 1, 1, 0};
    vt[12] = '{1,   1,  1, 1, 1, 1, 1, 0};
    vt[13] = '{2,   1,  1, 1, 1, 1, 1, 1};
    vt[14] = '{5,   10, 1, 1, 1, 1, 1, 1};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Raster checkpoints on the default timing, ticks every MCLK
    for (int k = 0; k < 15; k++) begin
      run_to(0, vt[k].h, vt[k].v, 5000);
      chk($sformatf("vec%0d h=%0d v=%0d", k, vt[k].h, vt[k].v),
          64'({hc[0], vc[0], hb[0], vb[0], hs[0], vs[0], sy[0], blk[0]}),
          64'({9'(vt[k].h), 9'(vt[k].v), vt[k].hb, vt[k].vb, vt[k].hs, vt[k].vs, vt[k].s, vt[k].blk}));
    end

    // Flip takes effect combinationally in the same cycle
    flip = 1'b1;
    #1;
    chk("flip_h", 64'(fh[0]), 64'(250));
    chk("flip_v", 64'(fv[0]), 64'(245));
    repeat (20) cycle(1'b1);
    flip = 1'b0;

    // Whole frame on the small raster: tick count and a single IRQ at V=VA,H=0
    run_to(1, 0, 0, 2000);
    n = 0; irq_cnt = 0; ih = -1; iv = -1;
    do begin
      cycle(1'b1);
      n++;
      if (irq[1]) begin
        irq_cnt++;
        ih = int'(hc[1]);
        iv = int'(vc[1]);
      end
    end while (!(hc[1] == 9'd0 && vc[1] == 9'd0) && n < 2000);
    chk("frame_ticks", 64'(n), 64'(TP_S.ht * TP_S.vt));
    chk("frame_irqs", 64'(irq_cnt), 64'(1));
    chk("irq_pos", 64'({ih, iv}), 64'({32'd0, TP_S.va}));

    // Ticks every 3 MCLK across vblank entry, then a 50-cycle gap with no ticks
    run_to(1, TP_S.ht - 6, TP_S.va - 1, 2000);
    irq_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc_cnt(1'b1); cyc_cnt(1'b0); cyc_cnt(1'b0);
    end
    repeat (50) cyc_cnt(1'b0);
    chk("gap_hold", 64'({hc[1], vc[1]}), 64'({9'd0, 9'(TP_S.va)}));
    for (int k = 0; k < 30; k++) begin
      cyc_cnt(1'b1); cyc_cnt(1'b0); cyc_cnt(1'b0);
    end
    chk("gap_irqs", 64'(irq_cnt), 64'(1));

    // Mid-frame reset on the default raster
    run_to(0, 100, 50, 40000);
    @(negedge clk);
    #2;
    rst_n  = 1'b0;
    tick_n = 1'b0;
    #1;
    check_reset("rst_mid");
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst_hold");
    @(negedge clk);
    tick_n = 1'b1;
    rst_n  = 1'b1;
    cycle(1'b1);
    chk("post_rst_h", 64'(hc[0]), 64'(1));
    chk("post_rst_v", 64'(vc[0]), 64'(0));
    repeat (10) cycle(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
